// File: rtl/sv32_ptw_ctrl.sv
// sv32_ptw_ctrl: Sv32 translation with a small fully associative TLB and a two-level sequential page walk
module sv32_ptw_ctrl #(
    parameter int         TLB_ENTRIES = 4,
    parameter logic [1:0] PRIV_M      = 2'b11
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    input  logic        req_is_write,
    input  logic [1:0]  priv_mode,
    input  logic [31:0] satp,
    input  logic        tlb_flush,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_fault,
    output logic        busy,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);
    localparam int IW = $clog2(TLB_ENTRIES);

    typedef enum logic [1:0] {IDLE, PTE1_RD, PTE2_RD, DONE} state_t;

    state_t                 state;
    logic [31:0]            va_q;
    logic                   wr_q;
    logic [19:0]            root_q;
    logic                   flushed_q;
    logic [TLB_ENTRIES-1:0] tlb_v;
    logic [TLB_ENTRIES-1:0] tlb_w;
    logic [19:0]            tlb_tag [TLB_ENTRIES];
    logic [19:0]            tlb_ppn [TLB_ENTRIES];
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          hit_idx;
    logic                   hit;
    logic                   m_req;
    logic                   pte_bad;
    logic                   pte2_fault;
    logic                   unused_bits;

    assign unused_bits = ^{satp[31:20], mem_rdata[31:30]};
    assign m_req       = priv_mode == PRIV_M;
    assign pte_bad     = !mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2]);
    assign pte2_fault  = pte_bad || (wr_q && !mem_rdata[2]);

    // TLB lookup; scanning downwards lets the lowest matching index win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (tlb_v[i] && tlb_tag[i] == req_vaddr[31:12]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Responses and PTE fetch strobes; IDLE answers are suppressed while in reset
    always_comb begin
        resp_valid = 1'b0;
        resp_paddr = '0;
        resp_fault = 1'b0;
        busy       = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                if (rstn && req_valid && (m_req || hit)) begin
                    resp_valid = 1'b1;
                    resp_fault = !m_req && req_is_write && !tlb_w[hit_idx];
                    resp_paddr = m_req ? req_vaddr : resp_fault ? '0 : {tlb_ppn[hit_idx], req_vaddr[11:0]};
                end
            end
            PTE1_RD: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = {root_q, va_q[31:22], 2'b00};
            end
            PTE2_RD: begin
                busy       = 1'b1;
                resp_valid = pte_bad;
                resp_fault = pte_bad;
                mem_en     = !pte_bad;
                mem_addr   = pte_bad ? '0 : {mem_rdata[29:10], va_q[21:12], 2'b00};
            end
            DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                resp_fault = pte2_fault;
                resp_paddr = pte2_fault ? '0 : {mem_rdata[29:10], va_q[11:0]};
            end
            default: ;
        endcase
    end

    // Walk sequencing, request latching and TLB flush/fill; a flush seen mid-walk blocks that walk's fill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            va_q      <= '0;
            wr_q      <= 1'b0;
            root_q    <= '0;
            flushed_q <= 1'b0;
            tlb_v     <= '0;
            tlb_w     <= '0;
            ptr       <= '0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_tag[i] <= '0;
                tlb_ppn[i] <= '0;
            end
        end else begin
            if (tlb_flush) tlb_v <= '0;
            if (tlb_flush && state != IDLE) flushed_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid && !m_req && !hit) begin
                        va_q      <= req_vaddr;
                        wr_q      <= req_is_write;
                        root_q    <= satp[19:0];
                        flushed_q <= 1'b0;
                        state     <= PTE1_RD;
                    end
                end
                PTE1_RD: state <= PTE2_RD;
                PTE2_RD: state <= pte_bad ? IDLE : DONE;
                DONE: begin
                    state <= IDLE;
                    if (!pte2_fault) begin
                        ptr <= ptr + IW'(1);
                        if (!flushed_q && !tlb_flush) begin
                            tlb_v[ptr]   <= 1'b1;
                            tlb_w[ptr]   <= mem_rdata[2];
                            tlb_tag[ptr] <= va_q[31:12];
                            tlb_ppn[ptr] <= mem_rdata[29:10];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sv32_ptw_ctrl.sv
// tb_sv32_ptw_ctrl: scenario tasks plus randomized traffic against a functional Sv32/TLB model
module tb_sv32_ptw_ctrl;
    logic        clk = 1'b0, rstn = 1'b0, req_valid = 1'b0, req_is_write = 1'b0, tlb_flush = 1'b0;
    logic [31:0] req_vaddr = '0, satp = '0, mem_rdata = '0;
    logic [1:0]  priv_mode = '0;
    logic        resp_valid, resp_fault, busy, mem_en;
    logic [31:0] resp_paddr, mem_addr;
    int          checks = 0, errors = 0, mem_cnt = 0;

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        int          lat;
        logic [31:0] pa;
        logic        f;
        int          mem;
        logic [31:0] a1;
        logic [31:0] a2;
        int          busy_bad;
        logic        fill;
        logic [19:0] ppn;
        logic        w;
    } res_t;

    logic        m_v   [4];
    logic [19:0] m_tag [4];
    logic [19:0] m_ppn [4];
    logic        m_w   [4];
    int          m_ptr;

    always #5 clk = ~clk;

    sv32_ptw_ctrl dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_vaddr(req_vaddr),
        .req_is_write(req_is_write), .priv_mode(priv_mode), .satp(satp), .tlb_flush(tlb_flush),
        .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_fault(resp_fault), .busy(busy),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem_rdata <= rd(mem_addr);
            mem_cnt++;
        end
    end

    function automatic res_t predict(input logic [31:0] va, input logic wr, input logic [1:0] pm);
        res_t        e;
        logic [31:0] p1, p2;
        int          h = -1;
        e = '{default: 0};
        if (pm == 2'b11) begin
            e.pa = va;
            return e;
        end
        for (int i = 3; i >= 0; i--) if (m_v[i] && m_tag[i] == va[31:12]) h = i;
        if (h >= 0) begin
            e.f  = wr && !m_w[h];
            e.pa = e.f ? 32'h0 : {m_ppn[h], va[11:0]};
            return e;
        end
        e.a1  = {satp[19:0], va[31:22], 2'b00};
        p1    = rd(e.a1);
        e.mem = 1;
        e.lat = 2;
        if (!p1[0] || (!p1[1] && p1[2])) begin
            e.f = 1'b1;
            return e;
        end
        e.a2   = {p1[29:10], va[21:12], 2'b00};
        p2     = rd(e.a2);
        e.mem  = 2;
        e.lat  = 3;
        e.f    = !p2[0] || (!p2[1] && p2[2]) || (wr && !p2[2]);
        e.fill = !e.f;
        e.ppn  = p2[29:10];
        e.w    = p2[2];
        e.pa   = e.f ? 32'h0 : {p2[29:10], va[11:0]};
        return e;
    endfunction

    function automatic void model_apply(input res_t e, input logic [31:0] va, input int fa);
        if (fa >= 0 && fa <= e.lat) for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        if (e.fill) begin
            if (!(fa >= 1 && fa <= e.lat)) begin
                m_v[m_ptr]   = 1'b1;
                m_tag[m_ptr] = va[31:12];
                m_ppn[m_ptr] = e.ppn;
                m_w[m_ptr]   = e.w;
            end
            m_ptr = (m_ptr + 1) % 4;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        m_ptr = 0;
    endfunction

    task automatic do_req(input logic [31:0] va, input logic wr, input logic [1:0] pm, input int fa, output res_t o);
        int m0;
        o = '{default: 0};
        o.lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = va; req_is_write = wr; priv_mode = pm;
        m0 = mem_cnt;
        for (int c = 0; c < 8 && o.lat < 0; c++) begin
            tlb_flush = (c == fa);
            #2;
            if (busy !== (c != 0)) o.busy_bad++;
            if (c == 1 && mem_en === 1'b1) o.a1 = mem_addr;
            if (c == 2 && mem_en === 1'b1) o.a2 = mem_addr;
            if (resp_valid === 1'b1) begin
                o.lat = c; o.pa = resp_paddr; o.f = resp_fault;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; tlb_flush = 1'b0;
        o.mem = mem_cnt - m0;
    endtask

    task automatic run(input logic [31:0] va, input logic wr, input logic [1:0] pm, input int fa, output res_t e, output res_t o);
        e = predict(va, wr, pm);
        do_req(va, wr, pm, fa, o);
        model_apply(e, va, fa);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        model_reset();
    endtask

    task automatic flush_idle();
        @(negedge clk); tlb_flush = 1'b1;
        @(negedge clk); tlb_flush = 1'b0;
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b1; priv_mode = 2'b11; req_vaddr = 32'h400;
        #3;
        checks++;
        if ({resp_valid, resp_fault, busy, mem_en} !== 4'b0 || resp_paddr !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v/f/busy/en=%b%b%b%b pa=%h ma=%h, want all zero",
                     resp_valid, resp_fault, busy, mem_en, resp_paddr, mem_addr);
        end
        @(negedge clk);
        req_valid = 1'b0; rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_mmode();
        res_t e, o;
        satp = 32'h1;
        run(32'h0000_0400, 1'b0, 2'b11, -1, e, o);
        checks++;
        if (o.lat !== 0 || o.pa !== 32'h400 || o.f !== 1'b0 || o.mem !== 0) begin
            errors++;
            $display("FAIL mmode: got lat=%0d pa=%h f=%b mem_en=%0d, want lat=0 pa=00000400 f=0 mem_en=0", o.lat, o.pa, o.f, o.mem);
        end
    endtask

    task automatic test_walk();
        res_t e, o;
        mem[32'h1004] = 32'h0000_0801;
        mem[32'h2004] = 32'h0000_0C0F;
        run(32'h0040_1234, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.a1 !== 32'h1004 || o.a2 !== 32'h2004) begin
            errors++;
            $display("FAIL walk_addrs: got %h %h, want 00001004 00002004", o.a1, o.a2);
        end
        checks++;
        if (o.lat !== 3 || o.pa !== 32'h3234 || o.f !== 1'b0) begin
            errors++;
            $display("FAIL walk_resp: got lat=%0d pa=%h f=%b, want lat=3 pa=00003234 f=0", o.lat, o.pa, o.f);
        end
        checks++;
        if (o.busy_bad !== 0 || o.mem !== 2) begin
            errors++;
            $display("FAIL walk_busy: got busy_errs=%0d mem_en=%0d, want 0 and 2", o.busy_bad, o.mem);
        end
        run(32'h0040_1234, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 0 || o.pa !== 32'h3234 || o.mem !== 0) begin
            errors++;
            $display("FAIL walk_rehit: got lat=%0d pa=%h mem_en=%0d, want lat=0 pa=00003234 mem_en=0", o.lat, o.pa, o.mem);
        end
    endtask

    task automatic test_faults();
        res_t e, o;
        run(32'h0080_0000, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 2 || o.f !== 1'b1 || o.pa !== 32'h0 || o.mem !== 1) begin
            errors++;
            $display("FAIL pte1_fault: got lat=%0d f=%b pa=%h mem_en=%0d, want lat=2 f=1 pa=0 mem_en=1", o.lat, o.f, o.pa, o.mem);
        end
        mem[32'h2008] = 32'h0000_0C05;
        for (int k = 0; k < 2; k++) begin
            run(32'h0040_2000, 1'b0, 2'b01, -1, e, o);
            checks++;
            if (o.lat !== 3 || o.f !== 1'b1 || o.pa !== 32'h0) begin
                errors++;
                $display("FAIL pte2_fault[%0d]: got lat=%0d f=%b pa=%h, want lat=3 f=1 pa=0", k, o.lat, o.f, o.pa);
            end
        end
        mem[32'h200C] = 32'h0000_1003;
        run(32'h0040_3010, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 3 || o.f !== 1'b0 || o.pa !== 32'h4010) begin
            errors++;
            $display("FAIL ro_load: got lat=%0d f=%b pa=%h, want lat=3 f=0 pa=00004010", o.lat, o.f, o.pa);
        end
        run(32'h0040_3010, 1'b1, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 0 || o.f !== 1'b1 || o.pa !== 32'h0) begin
            errors++;
            $display("FAIL ro_store: got lat=%0d f=%b pa=%h, want lat=0 f=1 pa=0", o.lat, o.f, o.pa);
        end
    endtask

    task automatic test_replacement();
        res_t e, o;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            mem[32'h2000 + 32'((5 + i) * 4)] = (32'(16 + i) << 10) | 32'hF;
            run(32'h0040_5000 + 32'(i * 32'h1000), 1'b0, 2'b01, -1, e, o);
            checks++;
            if (o.lat !== 3 || o.pa !== 32'(16 + i) << 12) begin
                errors++;
                $display("FAIL repl_fill[%0d]: got lat=%0d pa=%h, want lat=3 pa=%h", i, o.lat, o.pa, 32'(16 + i) << 12);
            end
        end
        run(32'h0040_6000, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 0 || o.pa !== 32'h0001_1000) begin
            errors++;
            $display("FAIL repl_second_hits: got lat=%0d pa=%h, want lat=0 pa=00011000", o.lat, o.pa);
        end
        run(32'h0040_5000, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 3 || o.pa !== 32'h0001_0000) begin
            errors++;
            $display("FAIL repl_first_evicted: got lat=%0d pa=%h, want lat=3 pa=00010000", o.lat, o.pa);
        end
    endtask

    task automatic test_flush();
        res_t e, o;
        int   want [6] = '{3, 3, 0, 3, 3, 3};
        int   fa   [5] = '{2, -1, 0, -1, -1};
        for (int k = 0; k < 5; k++) begin
            run(32'h0040_1234, 1'b0, 2'b01, fa[k], e, o);
            checks++;
            if (o.lat !== want[k] || o.pa !== 32'h3234 || o.f !== 1'b0) begin
                errors++;
                $display("FAIL flush_step[%0d]: got lat=%0d pa=%h f=%b, want lat=%0d pa=00003234 f=0", k, o.lat, o.pa, o.f, want[k]);
            end
            if (k == 3) flush_idle();
        end
        flush_idle();
        run(32'h0040_6000, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== want[5] || o.pa !== 32'h0001_1000) begin
            errors++;
            $display("FAIL flush_idle_miss: got lat=%0d pa=%h, want lat=3 pa=00011000", o.lat, o.pa);
        end
    endtask

    task automatic test_reset_midwalk();
        res_t e, o;
        flush_idle();
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = 32'h0040_1234; priv_mode = 2'b01; req_is_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h2004) begin
            errors++;
            $display("FAIL midwalk_pte2: got busy=%b mem_en=%b ma=%h, want 1 1 00002004", busy, mem_en, mem_addr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL midwalk_reset: got busy=%b resp_valid=%b mem_en=%b, want 0 0 0", busy, resp_valid, mem_en);
        end
        @(negedge clk);
        rstn = 1'b1; req_valid = 1'b0;
        model_reset();
        run(32'h0040_1234, 1'b0, 2'b01, -1, e, o);
        checks++;
        if (o.lat !== 3 || o.pa !== 32'h3234) begin
            errors++;
            $display("FAIL post_reset_miss: got lat=%0d pa=%h, want lat=3 pa=00003234", o.lat, o.pa);
        end
    endtask

    task automatic test_back_to_back();
        int c = 0;
        flush_idle();
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = 32'h0040_1234; priv_mode = 2'b01; req_is_write = 1'b0;
        #2;
        while (resp_valid !== 1'b1 && c < 8) begin
            @(negedge clk);
            #2;
            c++;
        end
        checks++;
        if (c !== 3) begin
            errors++;
            $display("FAIL b2b_walk_latency: got %0d, want 3", c);
        end
        @(negedge clk);
        #2;
        checks++;
        if (resp_valid !== 1'b1 || busy !== 1'b0 || resp_paddr !== 32'h3234) begin
            errors++;
            $display("FAIL b2b_held_hit: got v=%b busy=%b pa=%h, want 1 0 00003234", resp_valid, busy, resp_paddr);
        end
        @(negedge clk);
        req_valid = 1'b0;
        pulse_reset();
    endtask

    task automatic test_random();
        res_t        e, o;
        logic [31:0] va;
        int          k, r, fa;
        pulse_reset();
        for (int v = 16; v < 20; v++)
            mem[{20'h1, 10'(v), 2'b00}] = {2'($urandom), 20'(32'h100 + v), 6'($urandom),
                                           ($urandom_range(0, 3) != 0) ? 4'b0001 : 4'($urandom)};
        for (int j = 0; j < 8; j++) mem[{20'(32'h100 + 16 + j % 4), 10'(j), 2'b00}] = $urandom;
        for (int n = 0; n < 80; n++) begin
            k    = $urandom_range(0, 7);
            va   = {10'(16 + k % 4), 10'(k), 12'($urandom)};
            satp = {12'($urandom), 20'h1};
            r    = $urandom_range(0, 11);
            fa   = r < 4 ? r : -1;
            run(va, 1'($urandom), 2'($urandom), fa, e, o);
            checks++;
            if (o.lat !== e.lat || o.pa !== e.pa || o.f !== e.f || o.mem !== e.mem ||
                o.a1 !== e.a1 || o.a2 !== e.a2 || o.busy_bad !== 0) begin
                errors++;
                $display("FAIL random[%0d] va=%h: got lat=%0d pa=%h f=%b mem=%0d a1=%h a2=%h busy_errs=%0d, want lat=%0d pa=%h f=%b mem=%0d a1=%h a2=%h busy_errs=0",
                         n, va, o.lat, o.pa, o.f, o.mem, o.a1, o.a2, o.busy_bad, e.lat, e.pa, e.f, e.mem, e.a1, e.a2);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mmode();
        test_walk();
        test_faults();
        test_replacement();
        test_flush();
        test_reset_midwalk();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/sv32_ptw_ctrl.md
Name: sv32_ptw_ctrl

Overview:
- Sequential Sv32 address-translation controller for the memory stage.
- Replaces the combinational three-read-port page walk with a multi-cycle walker on one synchronous-read memory port.
- Fronts the walker with a 4-entry fully associative TLB. Hits and machine-mode accesses translate in the request cycle; misses stall the pipeline through a two-level walk.
- Sits between stage_mem and the data memory read port used for PTE fetches.

Parameters:
- TLB_ENTRIES, 4, number of TLB entries; power of two, 2..8.
- PRIV_M, 2'b11, privilege encoding that bypasses translation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  translation request; held with stable fields until resp_valid.
- req_vaddr  input  32  virtual address.
- req_is_write  input  1  request is a store.
- priv_mode  input  2  current privilege mode.
- satp  input  32  root page-table register; bits [19:0] used as root PPN.
- tlb_flush  input  1  invalidate all TLB entries (sfence.vma).
- resp_valid  output  1  translation result valid this cycle.
- resp_paddr  output  32  physical address; 0 when resp_fault=1.
- resp_fault  output  1  page fault; qualified by resp_valid.
- busy  output  1  walk in progress; pipeline stall.
- mem_en  output  1  PTE read strobe to data memory.
- mem_addr  output  32  PTE physical address.
- mem_rdata  input  32  PTE read data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rstn=0): state=IDLE, all TLB valid bits=0, replacement pointer=0, latched request regs=0, every output=0.
- States: IDLE, PTE1_RD, PTE2_RD, DONE.
- IDLE with req_valid and priv_mode==PRIV_M:
  - combinational resp_valid=1, resp_paddr=req_vaddr, resp_fault=0.
  - No TLB access.
- IDLE with req_valid, non-M, TLB hit (valid && tag==vaddr[31:12]):
  - combinational resp_valid=1, resp_paddr={ppn,vaddr[11:0]}.
  - If req_is_write and the entry's W=0: resp_fault=1, resp_paddr=0.
- IDLE with req_valid, non-M, miss:
  - latch vaddr, is_write, satp[19:0]; go to PTE1_RD; resp_valid=0.
- PTE1_RD:
  - mem_en=1, mem_addr={satp_q[19:0], va_q[31:22], 2'b00}.
  - busy=1; go to PTE2_RD.
- PTE2_RD: mem_rdata=pte1, busy=1.
  - Fault if pte1[0]==0 or (pte1[1]==0 && pte1[2]==1). On fault: resp_valid=1, resp_fault=1, then go to IDLE.
  - Otherwise: mem_en=1, mem_addr={pte1[29:10], va_q[21:12], 2'b00}, go to DONE.
- DONE: mem_rdata=pte2, busy=1, resp_valid=1.
  - Fault if pte2[0]==0, or (pte2[1]==0 && pte2[2]==1), or (is_write_q && pte2[2]==0).
  - Otherwise resp_paddr={pte2[29:10], va_q[11:0]}.
  - On no fault: fill the TLB entry at the replacement pointer (tag=va_q[31:12], ppn=pte2[29:10], W=pte2[2]) at the end of the cycle, and increment the pointer modulo TLB_ENTRIES.
  - Go to IDLE.
- Latency: hit or M-mode has 0 cycles. Miss gives resp_valid 3 cycles after acceptance (2 cycles when PTE1 faults).
- busy is 1 in PTE1_RD, PTE2_RD and DONE, and 0 in IDLE.
- Faulting translations are never cached.
- resp_valid is a per-cycle indication; the requester drops or changes its request the cycle after consuming it.
- A held request re-translates on the next cycle and hits the TLB.
- Address width rule: PPN fields are truncated to 20 bits; pte[31:30] and satp[31:20] are ignored.
- tlb_flush:
  - In IDLE: clears all valid bits at the clock edge. A same-cycle request still uses the pre-flush contents.
  - During a walk: clears valid bits, and the in-flight walk completes and responds but does not fill the TLB.
  - Flush and fill in the same cycle: flush wins, and the pointer still advances.
- Multiple hits (should not occur) resolve to the lowest index.
- Entering PRIV_M mid-walk does not abort the walk; the latched request completes.
- Reset mid-walk: immediate return to IDLE, mem_en=0, no TLB fill.

Test Plan:
- M-mode: priv_mode=2'b11, req_vaddr=32'h0000_0400 -> same-cycle resp_valid=1, resp_paddr=32'h0000_0400, mem_en never asserted.
- Miss walk: S-mode, satp=32'h0000_0001, vaddr=32'h0040_1234, pte1=32'h0000_0801, pte2=32'h0000_0C0F.
  - Cycle +1: mem_addr=32'h0000_1004.
  - Cycle +2: mem_addr=32'h0000_2004.
  - Cycle +3: resp_paddr=32'h0000_3234, busy 1 for 3 cycles.
  - Re-request: 0-cycle hit with the same paddr.
- Faults:
  - pte1=32'h0 -> fault at cycle +2 with a single mem_en.
  - pte2=32'h0000_0C05 (R=0, W=1) -> fault at +3, no TLB fill.
  - Load of a W=0 page, then store to it -> load succeeds; store hits the TLB and faults with resp_paddr=0.
- Replacement: 5 distinct missing VPNs -> 5th fill overwrites entry 0; the first VPN walks again, the second VPN hits.
- Flush: tlb_flush during PTE2_RD -> walk responds correctly; the following request to the same VPN misses. tlb_flush in IDLE -> all entries miss.
- Reset: drop rstn in PTE2_RD -> busy, resp_valid and mem_en go 0 immediately; after release the first request misses.
